// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Width of the read latency down-counter; it must hold READ_LAT itself.
  function automatic int lat_cnt_w(input int read_lat);
    return (read_lat < 1) ? 1 : $clog2(read_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// rtl/mem_arbiter_arb_rr2.sv - two-way round-robin grant with last-winner pointer
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_idx = REQ_CPU;
      2'b10:   grant_idx = REQ_DMA;
      default: grant_idx = ~last;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last <= REQ_DMA;
    end else if (update && grant_valid) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter and sequencer for one synchronous memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = lat_cnt_w(READ_LAT);

  arb_state_t        state;
  logic              owner;
  logic              is_wr;
  logic [CNT_W-1:0]  cnt;
  logic              grant_valid;
  logic              grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  arb_rr2 u_rr (
    .clock       (clock),
    .resetn      (resetn),
    .req         ({req1, req0}),
    .update      (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (grant_idx == REQ_DMA) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Reset clears mem_we asynchronously so an aborted write never lands.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= REQ_CPU;
      is_wr     <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            is_wr     <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            cnt       <= sel_we ? '0 : CNT_W'(READ_LAT);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (is_wr || cnt == '0) begin
            mem_we <= 1'b0;
            if (!is_wr) begin
              rdata <= mem_rdata;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0 = (state == ST_DONE) && (owner == REQ_CPU);
  assign ack1 = (state == ST_DONE) && (owner == REQ_DMA);
  assign busy = (state != ST_IDLE);

endmodule
